// File: rtl/rvb_issue_ctrl_pkg.sv
// rtl/rvb_issue_ctrl_pkg.sv - shared constants and helpers for the bitmanip issue controller
package rvb_issue_ctrl_pkg;

    localparam int RVB_INSN_B3  = 3;
    localparam int RVB_INSN_B13 = 13;
    localparam int RVB_INSN_B14 = 14;

    function automatic int rvb_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic bit rvb_xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

    function automatic bit rvb_depth_legal(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/rvb_issue_ctrl_if.sv
// rtl/rvb_issue_ctrl_if.sv - core request/response and unit din/dout signal bundle
interface rvb_issue_ctrl_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;
    logic [31:0]     req_insn;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rd;

    logic            din_valid;
    logic            din_ready;
    logic [XLEN-1:0] din_rs1;
    logic [XLEN-1:0] din_rs2;
    logic            din_insn3;
    logic            din_insn13;
    logic            din_insn14;

    logic            dout_valid;
    logic [XLEN-1:0] dout_rd;

    logic            err_overflow;

    modport master (
        input  req_valid, req_rs1, req_rs2, req_insn,
        output req_ready,
        output rsp_valid, rsp_rd,
        input  rsp_ready,
        output din_valid, din_rs1, din_rs2, din_insn3, din_insn13, din_insn14,
        input  din_ready,
        input  dout_valid, dout_rd,
        output err_overflow
    );

    modport slave (
        output req_valid, req_rs1, req_rs2, req_insn,
        input  req_ready,
        input  rsp_valid, rsp_rd,
        output rsp_ready,
        input  din_valid, din_rs1, din_rs2, din_insn3, din_insn13, din_insn14,
        output din_ready,
        output dout_valid, dout_rd,
        input  err_overflow
    );

endinterface

// File: rtl/rvb_sync_fifo.sv
// rtl/rvb_sync_fifo.sv - W x DEPTH synchronous FIFO with occupancy count
module rvb_sync_fifo
    import rvb_issue_ctrl_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int PW    = rvb_clog2(DEPTH),
    parameter int CW    = PW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A push against a full FIFO is dropped rather than overwriting the oldest entry.
    assign do_push  = push & (count != CW'(DEPTH));
    assign do_pop   = pop & (count != '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/rvb_issue_ctrl.sv
// rtl/rvb_issue_ctrl.sv - bitmanip unit issue controller with credit-protected in-order result FIFO
// Optional RVB_ISSUE_BYPASS_EN hands a result straight to the core when the FIFO is empty.
module rvb_issue_ctrl
    import rvb_issue_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input logic              clock,
    input logic              reset,
    rvb_issue_ctrl_if.master bus
);

    localparam int PW = rvb_clog2(DEPTH);
    localparam int CW = PW + 1;

    if (!rvb_xlen_legal(XLEN)) begin : g_bad_xlen
        $error("rvb_issue_ctrl: XLEN must be 32 or 64");
    end
    if (!rvb_depth_legal(DEPTH)) begin : g_bad_depth
        $error("rvb_issue_ctrl: DEPTH must be a power of two and at least 2");
    end

    logic [CW-1:0]   inflight;
    logic [CW-1:0]   count;
    logic [CW:0]     occupancy;
    logic            credit_ok;
    logic            issue;
    logic            bypass;
    logic            push;
    logic            pop;
    logic            fifo_valid;
    logic [XLEN-1:0] fifo_data;
    logic            err_q;
    logic            unused_ok;

    // Every op holds a credit from issue until the core takes its result, so the
    // FIFO always has room for a result the unit cannot hold back.
    assign occupancy = {1'b0, inflight} + {1'b0, count};
    assign credit_ok = occupancy < (CW+1)'(DEPTH);

    assign bus.din_valid  = bus.req_valid & credit_ok;
    assign bus.req_ready  = bus.din_ready & credit_ok;
    assign bus.din_rs1    = bus.req_rs1;
    assign bus.din_rs2    = bus.req_rs2;
    assign bus.din_insn13 = bus.req_insn[RVB_INSN_B13];
    assign bus.din_insn14 = bus.req_insn[RVB_INSN_B14];
    assign bus.din_insn3  = (XLEN == 64) ? bus.req_insn[RVB_INSN_B3] : 1'b0;
    assign unused_ok      = &{1'b0, bus.req_insn};

    assign issue = bus.din_valid & bus.din_ready;

`ifdef RVB_ISSUE_BYPASS_EN
    assign bypass = bus.dout_valid & (count == '0) & bus.rsp_ready;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_valid    = (count != '0);
    assign push          = bus.dout_valid & ~bypass;
    assign pop           = bus.rsp_valid & bus.rsp_ready & ~bypass;
    assign bus.rsp_valid = fifo_valid | bypass;
    assign bus.rsp_rd    = bypass ? bus.dout_rd : fifo_data;
    assign bus.err_overflow = err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            inflight <= '0;
            err_q    <= 1'b0;
        end else begin
            if (issue && !bus.dout_valid) begin
                inflight <= inflight + 1'b1;
            end else if (!issue && bus.dout_valid && inflight != '0) begin
                inflight <= inflight - 1'b1;
            end
            // A result with nothing outstanding means the unit misbehaved; remember it.
            if (bus.dout_valid && inflight == '0) begin
                err_q <= 1'b1;
            end
        end
    end

    rvb_sync_fifo #(
        .W     (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (bus.dout_rd),
        .pop       (pop),
        .pop_data  (fifo_data),
        .count     (count)
    );

endmodule
